// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode circular instruction queue with early-full throttle and flush discard
module inst_queue #(
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 inst_rdy,
  input  logic [31:0]          inst_in,
  input  logic [31:0]          pc_in,
  output logic                 inst_full,
  input  logic                 flush,
  input  logic                 dec_ready,
  output logic                 dec_valid,
  output logic [31:0]          dec_inst,
  output logic [31:0]          dec_pc,
  output logic [DEPTH_LOG:0]   count
);
  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] CNT_MAX = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CNT_THR = (DEPTH_LOG + 1)'(DEPTH - 1);
  localparam logic [DEPTH_LOG:0] CNT_ONE = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic [DEPTH_LOG-1:0] head, tail;
  logic [DEPTH_LOG:0] cnt, cnt_n;
  logic flush_d, push, pop;
  always_comb begin
    dec_valid = rdy & (cnt != '0);
    dec_inst = mem_inst[head];
    dec_pc = mem_pc[head];
    inst_full = cnt >= CNT_THR;
    count = cnt;
    // push is judged against the pre-edge count, so a push at full is dropped even with a pop
    push = rdy & inst_rdy & !flush & !flush_d & (cnt < CNT_MAX);
    pop = dec_valid & dec_ready & !flush;
    cnt_n = (push & !pop) ? cnt + CNT_ONE : (pop & !push) ? cnt - CNT_ONE : cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      flush_d <= 1'b0;
    end else if (rdy) begin
      flush_d <= flush;
      head <= flush ? '0 : pop ? head + PTR_ONE : head;
      tail <= flush ? '0 : push ? tail + PTR_ONE : tail;
      cnt <= flush ? '0 : cnt_n;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[tail] <= inst_in;
      mem_pc[tail] <= pc_in;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: scoreboard bench for inst_queue (DEPTH=8)
module tb_inst_queue;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk = 0, rst = 0, rdy = 1, inst_rdy = 0, flush = 0, dec_ready = 0;
  logic [31:0] inst_in = 0, pc_in = 0;
  logic inst_full, dec_valid;
  logic [31:0] dec_inst, dec_pc;
  logic [3:0] count;
  int n_cmp = 0, n_bad = 0;
  int mcnt = 0;
  bit mfd = 0;
  logic [31:0] sb[$];

  inst_queue #(.DEPTH_LOG(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .inst_rdy(inst_rdy), .inst_in(inst_in), .pc_in(pc_in),
    .inst_full(inst_full), .flush(flush), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic ir, input logic [31:0] pc, input logic dr, input logic fl, input logic r);
    bit mp, mq;
    @(negedge clk);
    inst_rdy = ir; pc_in = pc; inst_in = pc ^ KEY; dec_ready = dr; flush = fl; rdy = r;
    mp = r & ir & !fl & !mfd & (mcnt < 8);
    mq = r & dr & !fl & (mcnt > 0);
    @(posedge clk);
    #1;
    if (r & fl) begin
      sb.delete();
      mcnt = 0;
    end else begin
      if (mq) void'(sb.pop_front());
      if (mp) sb.push_back(pc);
      mcnt = mcnt + int'(mp) - int'(mq);
    end
    if (r) mfd = fl;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1; inst_rdy = 1; pc_in = 32'h55; inst_in = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; inst_rdy = 0;
    sb.delete(); mcnt = 0; mfd = 0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dec_valid); end
    n_cmp++; if (inst_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", inst_full); end
  endtask

  task automatic test_fill;
    int k;
    for (int i = 0; i < 9; i++) begin
      cyc(1, 32'(i * 4), 0, 0, 1);
      n_cmp++; if (count !== 4'(mcnt)) begin n_bad++; $display("FAIL fill_count got %0d want %0d", count, mcnt); end
      n_cmp++; if (inst_full !== (mcnt >= 7)) begin n_bad++; $display("FAIL fill_full got %b want %b", inst_full, mcnt >= 7); end
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_max got %0d want 8", count); end
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== sb[0] || dec_inst !== (sb[0] ^ KEY)) begin
        n_bad++; $display("FAIL fill_drain got v=%b pc=%h inst=%h want pc=%h", dec_valid, dec_pc, dec_inst, sb[0]);
      end
      n_cmp++; if (dec_pc !== 32'(k * 4)) begin n_bad++; $display("FAIL fill_order got %h want %h", dec_pc, k * 4); end
      cyc(0, 0, 1, 0, 1);
      k++;
    end
    n_cmp++; if (dec_valid !== 1'b0 || sb.size() != 0) begin n_bad++; $display("FAIL fill_empty got v=%b left=%0d want 0", dec_valid, sb.size()); end
  endtask

  task automatic test_wrap;
    logic [31:0] pc = 32'h1000;
    logic ir, dr;
    int k = 0;
    for (int i = 0; i < 40; i++) begin
      ir = (i % 8) < 5;
      dr = (i % 8) >= 5 || i >= 32;
      if (dr && mcnt > 0) begin
        n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== sb[0]) begin n_bad++; $display("FAIL wrap_head got v=%b pc=%h want %h", dec_valid, dec_pc, sb[0]); end
      end
      cyc(ir, pc, dr, 0, 1);
      if (ir) pc += 4;
      n_cmp++; if (count !== 4'(mcnt) || count > 4'd8) begin n_bad++; $display("FAIL wrap_count got %0d want %0d", count, mcnt); end
    end
    while (sb.size() > 0 && k < 20) begin
      n_cmp++; if (dec_pc !== sb[0]) begin n_bad++; $display("FAIL wrap_drain got %h want %h", dec_pc, sb[0]); end
      cyc(0, 0, 1, 0, 1);
      k++;
    end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL wrap_empty got %0d want 0", count); end
  endtask

  task automatic test_flush;
    int k = 0;
    for (int i = 0; i < 4; i++) cyc(1, 32'h200 + 32'(i * 4), 0, 0, 1);
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL flush_pre got %0d want 4", count); end
    cyc(1, 32'h40, 1, 1, 1);
    n_cmp++; if (count !== 4'd0 || dec_valid !== 1'b0) begin n_bad++; $display("FAIL flush_now got c=%0d v=%b want 0", count, dec_valid); end
    cyc(1, 32'h44, 0, 0, 1);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_stale got %0d want 0", count); end
    cyc(1, 32'h100, 0, 0, 1);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 || count !== 4'd1) begin
      n_bad++; $display("FAIL flush_resume got v=%b pc=%h c=%0d want 1/100/1", dec_valid, dec_pc, count);
    end
    while (sb.size() > 0 && k < 20) begin
      n_cmp++; if (dec_pc !== sb[0]) begin n_bad++; $display("FAIL flush_drain got %h want %h", dec_pc, sb[0]); end
      cyc(0, 0, 1, 0, 1);
      k++;
    end
  endtask

  task automatic test_rdy_stall;
    int k = 0;
    for (int i = 0; i < 3; i++) cyc(1, 32'h400 + 32'(i * 4), 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h500, 1, 1, 0);
      n_cmp++; if (dec_valid !== 1'b0 || count !== 4'd3) begin n_bad++; $display("FAIL stall_hold got v=%b c=%0d want 0/3", dec_valid, count); end
    end
    cyc(0, 0, 0, 0, 1);
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h400 || count !== 4'd3) begin
      n_bad++; $display("FAIL stall_resume got v=%b pc=%h c=%0d want 1/400/3", dec_valid, dec_pc, count);
    end
    while (sb.size() > 0 && k < 20) begin
      n_cmp++; if (dec_pc !== sb[0]) begin n_bad++; $display("FAIL stall_drain got %h want %h", dec_pc, sb[0]); end
      cyc(0, 0, 1, 0, 1);
      k++;
    end
  endtask

  task automatic test_full_push_pop;
    int k = 0;
    for (int i = 0; i < 8; i++) cyc(1, 32'h300 + 32'(i * 4), 0, 0, 1);
    n_cmp++; if (count !== 4'd8 || dec_pc !== 32'h300) begin n_bad++; $display("FAIL pp_pre got c=%0d pc=%h want 8/300", count, dec_pc); end
    cyc(1, 32'h999, 1, 0, 1);
    n_cmp++; if (count !== 4'd7 || dec_pc !== 32'h304) begin n_bad++; $display("FAIL pp_at_full got c=%0d pc=%h want 7/304", count, dec_pc); end
    while (sb.size() > 0 && k < 20) begin
      n_cmp++; if (dec_pc !== sb[0] || dec_pc === 32'h999) begin n_bad++; $display("FAIL pp_drain got %h want %h", dec_pc, sb[0]); end
      cyc(0, 0, 1, 0, 1);
      k++;
    end
    n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty got %b want 0", dec_valid); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_flush;
    test_rdy_stall;
    test_full_push_pop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
